// File: rtl/mdu_pkg.sv
// Shared constants for the execute stage: ALU/MDU op codes, MDU state encoding and op-decoding helpers.
// MADD/MADDU decode only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int DIV_STEPS = 32;

  function automatic logic op_is_mul(input logic [2:0] op);
    logic hit;
    hit = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    hit = hit || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
    return hit;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// 32-step unsigned restoring divider. The first step is taken on the load edge so the
// final quotient/remainder are stable during the 32nd busy cycle of the parent.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [5:0]  cnt_q;
  logic [63:0] step_d;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits and record the quotient bit.
  function automatic logic [63:0] div_step(input logic [31:0] r,
                                           input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {r, q[31]};
    diff = sh - {1'b0, d};
    if (diff[32])
      return {sh[31:0], q[30:0], 1'b0};
    else
      return {diff[31:0], q[30:0], 1'b1};
  endfunction

  always_comb begin
    step_d = 64'd0;
    if (load)
      step_d = div_step(32'd0, dividend, divisor);
    else
      step_d = div_step(rem_q, quo_q, dsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dsr_q <= 32'd0;
      cnt_q <= 6'd0;
    end else if (load) begin
      rem_q <= step_d[63:32];
      quo_q <= step_d[31:0];
      dsr_q <= divisor;
      cnt_q <= 6'(DIV_STEPS - 1);
    end else if (cnt_q != 6'd0) begin
      rem_q <= step_d[63:32];
      quo_q <= step_d[31:0];
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (cnt_q == 6'd0);

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: fixed-latency multiply, 32-cycle divide, MTHI/MTLO.
// Define MDU_MADD_EN to add MADD/MADDU (accumulate product into {HI,LO}).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  input  logic        WE,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        qneg_q;
  logic        rneg_q;
  logic        dz_q;

  logic        start_mul;
  logic        start_div;
  logic        div_load;
  logic        sgn_in;
  logic [31:0] a_abs_d;
  logic [31:0] b_abs_d;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_done;
  logic [63:0] prod_d;
  logic [63:0] mul_res_d;
  logic [31:0] quo_fix_d;
  logic [31:0] rem_fix_d;

  assign start_mul = Start && op_is_mul(MDUOp);
  assign start_div = Start && op_is_div(MDUOp);
  assign div_load  = (state_q == ST_IDLE) && start_div;
  assign sgn_in    = op_is_signed(MDUOp);
  assign a_abs_d   = (sgn_in && MDU_A[31]) ? -MDU_A : MDU_A;
  assign b_abs_d   = (sgn_in && MDU_B[31]) ? -MDU_B : MDU_B;

  mdu_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (a_abs_d),
    .divisor   (b_abs_d),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    prod_d = 64'd0;
    if (op_is_signed(op_q))
      prod_d = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    else
      prod_d = {32'd0, a_q} * {32'd0, b_q};
  end

`ifdef MDU_MADD_EN
  assign mul_res_d = op_is_acc(op_q) ? ({hi_q, lo_q} + prod_d) : prod_d;
`else
  assign mul_res_d = prod_d;
`endif

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  // The 0x80000000 / -1 case falls out naturally as a 32-bit wrap.
  assign quo_fix_d = qneg_q ? -div_quo : div_quo;
  assign rem_fix_d = rneg_q ? -div_rem : div_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_mul) begin
            a_q     <= MDU_A;
            b_q     <= MDU_B;
            op_q    <= MDUOp;
            cnt_q   <= 6'(MULT_LAT);
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end else if (start_div) begin
            op_q    <= MDUOp;
            qneg_q  <= sgn_in && (MDU_A[31] ^ MDU_B[31]);
            rneg_q  <= sgn_in && MDU_A[31];
            dz_q    <= (MDU_B == 32'd0);
            cnt_q   <= 6'(DIV_STEPS);
            busy_q  <= 1'b1;
            state_q <= ST_DIV;
          end else if (WE && !Start) begin
            if (MDUOp == MDU_MTHI)
              hi_q <= MDU_A;
            else if (MDUOp == MDU_MTLO)
              lo_q <= MDU_A;
          end
        end
        ST_MUL: begin
          if (cnt_q == 6'd1) begin
            hi_q    <= mul_res_d[63:32];
            lo_q    <= mul_res_d[31:0];
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ST_DIV: begin
          if (cnt_q == 6'd1) begin
            if (!dz_q && div_done) begin
              hi_q <= rem_fix_d;
              lo_q <= quo_fix_d;
            end
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: begin
          cnt_q   <= 6'd0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a cycle-level reference model of HI/LO/Busy checked every cycle,
// plus hand-computed literal expectations.
module tb_mdu;
  import mdu_pkg::*;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  MDUOp = 3'd0;
  logic [31:0] MDU_A = 32'd0;
  logic [31:0] MDU_B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int miscompares = 0;

  mdu #(.MULT_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MDU_A (MDU_A),
    .MDU_B (MDU_B),
    .MDUOp (MDUOp),
    .Start (Start),
    .WE    (WE),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Reference model: result computed arithmetically at acceptance, held until busy time expires.
  int          m_rem;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  logic        m_wr;
  logic        m_acc;
  logic [64:0] dr;

  function automatic logic [64:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 65'd0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b1, 32'h0, 32'h8000_0000};
    if (sgn) return {1'b1, 32'(sa % sb), 32'(sa / sb)};
    return {1'b1, a % b, a / b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
      m_res <= 64'd0;
      m_wr  <= 1'b0;
      m_acc <= 1'b0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin
        if (m_acc) {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
        else       {m_hi, m_lo} <= m_res;
      end
    end else if (Start) begin
      case (MDUOp)
        MDU_MULT: begin
          m_res <= 64'(longint'($signed(MDU_A)) * longint'($signed(MDU_B)));
          m_wr <= 1'b1; m_acc <= 1'b0; m_rem <= LAT;
        end
        MDU_MULTU: begin
          m_res <= {32'd0, MDU_A} * {32'd0, MDU_B};
          m_wr <= 1'b1; m_acc <= 1'b0; m_rem <= LAT;
        end
`ifdef MDU_MADD_EN
        MDU_MADD: begin
          m_res <= 64'(longint'($signed(MDU_A)) * longint'($signed(MDU_B)));
          m_wr <= 1'b1; m_acc <= 1'b1; m_rem <= LAT;
        end
        MDU_MADDU: begin
          m_res <= {32'd0, MDU_A} * {32'd0, MDU_B};
          m_wr <= 1'b1; m_acc <= 1'b1; m_rem <= LAT;
        end
`endif
        MDU_DIV, MDU_DIVU: begin
          dr = div_ref(MDU_A, MDU_B, MDUOp == MDU_DIV);
          m_res <= dr[63:0];
          m_wr <= dr[64]; m_acc <= 1'b0; m_rem <= 32;
        end
        default: ;
      endcase
    end else if (WE) begin
      if (MDUOp == MDU_MTHI) m_hi <= MDU_A;
      else if (MDUOp == MDU_MTLO) m_lo <= MDU_A;
    end
  end

  always @(posedge clk) begin
    #1;
    vectors++;
    if (Busy !== (m_rem != 0) || HI !== m_hi || LO !== m_lo) begin
      miscompares++;
      $display("FAIL model t=%0t got Busy=%b HI=%h LO=%h expected Busy=%b HI=%h LO=%h",
               $time, Busy, HI, LO, (m_rem != 0), m_hi, m_lo);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic we);
    @(negedge clk);
    MDUOp = op; MDU_A = a; MDU_B = b; Start = st; WE = we;
    @(negedge clk);
    Start = 1'b0; WE = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout got %0d cycles expected below 200", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    rst_n = 1'b1;

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    wait_idle(n);
    check("mult_busy_cycles", n, LAT);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    wait_idle(n);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_idle(n);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'h0);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_idle(n);
    check("div_busy_cycles", n, 32);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_idle(n);
    check("div_negdsr_lo", LO, 32'hFFFF_FFFD);
    check("div_negdsr_hi", HI, 32'd1);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_idle(n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, 1'b1);
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b0, 1'b1);
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
    wait_idle(n);
    check("divz_busy_cycles", n, 32);
    check("divz_hi", HI, 32'h11);
    check("divz_lo", LO, 32'h22);

    issue(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, Busy}, 32'd0);

    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    issue(MDU_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1);
    check("we_in_div_hi", HI, 32'h1234_5678);
    wait_idle(n);
    check("divu_hi", HI, 32'd2);
    check("divu_lo", LO, 32'd14);

    issue(MDU_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_idle(n);
    check("overlap_busy_rest", n, LAT - 2);
    repeat (3) @(negedge clk);
    check("overlap_busy_after", {31'd0, Busy}, 32'd0);
    check("overlap_lo", LO, 32'd12);
    check("overlap_hi", HI, 32'd0);

    issue(MDU_MTLO, 32'h5555_5555, 32'd0, 1'b1, 1'b1);
    check("start_we_lo", LO, 32'd12);
    check("start_we_busy", {31'd0, Busy}, 32'd0);
    issue(MDU_MULTU, 32'd5, 32'd5, 1'b1, 1'b1);
    wait_idle(n);
    check("start_we_mul_lo", LO, 32'd25);

    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, 1'b1);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    issue(MDU_MADDU, 32'd1, 32'd1, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    wait_idle(n);
    check("maddu_busy_cycles", n, LAT);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    check("maddu_off_busy", {31'd0, Busy}, 32'd0);
    repeat (LAT + 1) @(negedge clk);
    check("maddu_off_hi", HI, 32'd0);
    check("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

    issue(MDU_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0, 1'b1);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    MDUOp = MDU_MULTU; MDU_A = 32'd6; MDU_B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("post_reset_busy", {31'd0, Busy}, 32'd1);
    wait_idle(n);
    check("post_reset_lo", LO, 32'd42);
    check("post_reset_hi", HI, 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
